// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, funct3 values, immediate formats and the
// per-unit enable bundle produced by the decode stage.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;
  localparam logic [2:0] F3_ADD_SUB   = 3'b000;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic up;
    logic up_pc_sel;
    logic alu;
    logic alu_src_imm;
    logic branch;
    logic jal;
    logic jalr;
    logic load;
    logic store;
    logic system;
  } unit_en_t;

  function automatic logic writes_rd(input logic [6:0] opcode);
    return (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
           (opcode == OP_JALR) || (opcode == OP_LOAD) || (opcode == OP_OP_IMM) ||
           (opcode == OP_OP);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction; every format sign-extends from instr[31].
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J:   imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// Registered RV32I decode stage: fields, immediate and one-hot unit enables,
// held on stall and bubbled on flush.
module decode
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_if_valid,
  input  logic [31:0]     i_if_instr,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_immediate,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  output logic [4:0]      o_rd_addr,
  output logic            o_rd_we,
  output logic [2:0]      o_funct3,
  output logic            o_funct7b5,
  output logic            o_up_en,
  output logic            o_up_pc_sel,
  output logic            o_alu_en,
  output logic            o_alu_src_imm,
  output logic            o_branch_en,
  output logic            o_jal_en,
  output logic            o_jalr_en,
  output logic            o_load_en,
  output logic            o_store_en,
  output logic            o_system_en,
  output logic            o_illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  imm_type_e       imm_type;
  logic [XLEN-1:0] imm_next;
  unit_en_t        en_dec;
  logic            legal_dec;
  logic            live_next;

  unit_en_t        en_reg;
  logic            valid_reg;
  logic            illegal_reg;
  logic            rd_we_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] imm_reg;
  logic [4:0]      rs1_reg;
  logic [4:0]      rs2_reg;
  logic [4:0]      rd_reg;
  logic [2:0]      funct3_reg;
  logic            funct7b5_reg;

  assign opcode = i_if_instr[6:0];
  assign funct3 = i_if_instr[14:12];
  assign funct7 = i_if_instr[31:25];
  assign rd     = i_if_instr[11:7];

  always_comb begin
    en_dec    = '0;
    imm_type  = IMM_NONE;
    legal_dec = 1'b1;
    case (opcode)
      OP_LUI: begin
        en_dec.up = 1'b1;
        imm_type  = IMM_U;
      end
      OP_AUIPC: begin
        en_dec.up        = 1'b1;
        en_dec.up_pc_sel = 1'b1;
        imm_type         = IMM_U;
      end
      OP_JAL: begin
        en_dec.jal = 1'b1;
        imm_type   = IMM_J;
      end
      OP_JALR: begin
        en_dec.jalr = 1'b1;
        imm_type    = IMM_I;
        legal_dec   = (funct3 == 3'b000);
      end
      OP_BRANCH: begin
        en_dec.branch = 1'b1;
        imm_type      = IMM_B;
        legal_dec     = funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
      end
      OP_LOAD: begin
        en_dec.load = 1'b1;
        imm_type    = IMM_I;
        legal_dec   = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      end
      OP_STORE: begin
        en_dec.store = 1'b1;
        imm_type     = IMM_S;
        legal_dec    = funct3 inside {F3_SB, F3_SH, F3_SW};
      end
      OP_OP_IMM: begin
        en_dec.alu         = 1'b1;
        en_dec.alu_src_imm = 1'b1;
        imm_type           = IMM_I;
        // Only the shift forms constrain the upper immediate bits.
        if (funct3 == F3_SLLI)
          legal_dec = (funct7 == F7_ZERO);
        else if (funct3 == F3_SRLI_SRAI)
          legal_dec = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
      end
      OP_OP: begin
        en_dec.alu = 1'b1;
        legal_dec  = (funct7 == F7_ZERO) ||
                     ((funct7 == F7_ALT) &&
                      ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRLI_SRAI)));
      end
      OP_MISC_MEM: imm_type = IMM_I;
      OP_SYSTEM: begin
        en_dec.system = 1'b1;
        imm_type      = IMM_I;
      end
      default: legal_dec = 1'b0;
    endcase
    if (i_if_instr[1:0] != 2'b11)
      legal_dec = 1'b0;
  end

  assign live_next = i_if_valid && legal_dec;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (i_if_instr),
    .imm_type (imm_type),
    .imm      (imm_next)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_reg    <= 1'b0;
      illegal_reg  <= 1'b0;
      rd_we_reg    <= 1'b0;
      en_reg       <= '0;
      pc_reg       <= '0;
      imm_reg      <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
      funct3_reg   <= '0;
      funct7b5_reg <= 1'b0;
    end else if (i_flush) begin
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      rd_we_reg   <= 1'b0;
      en_reg      <= '0;
    end else if (!i_stall) begin
      valid_reg    <= i_if_valid;
      illegal_reg  <= i_if_valid && !legal_dec;
      rd_we_reg    <= live_next && writes_rd(opcode) && (rd != 5'd0);
      en_reg       <= live_next ? en_dec : '0;
      pc_reg       <= i_if_pc;
      imm_reg      <= imm_next;
      rs1_reg      <= i_if_instr[19:15];
      rs2_reg      <= i_if_instr[24:20];
      rd_reg       <= rd;
      funct3_reg   <= funct3;
      funct7b5_reg <= i_if_instr[30];
    end
  end

  assign o_valid       = valid_reg;
  assign o_illegal     = illegal_reg;
  assign o_rd_we       = rd_we_reg;
  assign o_pc          = pc_reg;
  assign o_immediate   = imm_reg;
  assign o_rs1_addr    = rs1_reg;
  assign o_rs2_addr    = rs2_reg;
  assign o_rd_addr     = rd_reg;
  assign o_funct3      = funct3_reg;
  assign o_funct7b5    = funct7b5_reg;
  assign o_up_en       = en_reg.up;
  assign o_up_pc_sel   = en_reg.up_pc_sel;
  assign o_alu_en      = en_reg.alu;
  assign o_alu_src_imm = en_reg.alu_src_imm;
  assign o_branch_en   = en_reg.branch;
  assign o_jal_en      = en_reg.jal;
  assign o_jalr_en     = en_reg.jalr;
  assign o_load_en     = en_reg.load;
  assign o_store_en    = en_reg.store;
  assign o_system_en   = en_reg.system;

endmodule
